// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multi-cycle MIPS multiply/divide sequencer:
// FSM state encoding, shared-ALU control codes and carry/borrow recovery from MSBs.
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // The shared ALU exposes no flags, so carry/borrow are rebuilt from operand and result MSBs.
    function automatic logic alu_carry(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb);
    endfunction

    function automatic logic alu_borrow(input logic a_msb, input logic b_msb, input logic diff_msb);
        return (~a_msb & b_msb) | (~(a_msb ^ b_msb) & diff_msb);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_cond_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/multu/div/divu sequencer: drives the shared ALU for N shift-add or
// restoring-divide iterations and owns the HI/LO result registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         is_div,
    input  logic         is_signed,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic [N-1:0] alu_srcA,
    output logic [N-1:0] alu_srcB,
    output logic [2:0]   alu_ctrl_sig,
    input  logic [N-1:0] alu_out,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CNT_W = $clog2(N);

    state_t             r_state;
    logic               r_is_div;
    logic               r_is_signed;
    logic [N-1:0]       r_op_a;
    logic [N-1:0]       r_op_b;
    logic [N-1:0]       r_opnd;     // multiplicand or divisor magnitude
    logic [N-1:0]       r_acc;      // product high half / partial remainder
    logic [N-1:0]       r_mq;       // multiplier shifting out / quotient shifting in
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [N-1:0]       r_hi;
    logic [N-1:0]       r_lo;

    logic [N-1:0]       w_abs_a;
    logic [N-1:0]       w_abs_b;
    logic [2*N-1:0]     w_prod_fix;
    logic [N-1:0]       w_q_fix;
    logic [N-1:0]       w_rem_fix;
    logic [N-1:0]       w_rem_shift;
    logic [N-1:0]       w_q_shift;
    logic               w_carry;
    logic               w_borrow;

    cond_neg #(.W(N)) u_abs_a (
        .i_val (r_op_a),
        .i_neg (r_is_signed & r_op_a[N-1]),
        .o_val (w_abs_a)
    );

    cond_neg #(.W(N)) u_abs_b (
        .i_val (r_op_b),
        .i_neg (r_is_signed & r_op_b[N-1]),
        .o_val (w_abs_b)
    );

    cond_neg #(.W(2*N)) u_fix_prod (
        .i_val ({r_acc, r_mq}),
        .i_neg (r_neg_res),
        .o_val (w_prod_fix)
    );

    cond_neg #(.W(N)) u_fix_quot (
        .i_val (r_mq),
        .i_neg (r_neg_res),
        .o_val (w_q_fix)
    );

    cond_neg #(.W(N)) u_fix_rem (
        .i_val (r_acc),
        .i_neg (r_neg_rem),
        .o_val (w_rem_fix)
    );

    assign w_rem_shift = {r_acc[N-2:0], r_mq[N-1]};
    assign w_q_shift   = {r_mq[N-2:0], 1'b0};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_srcA     = '0;
        alu_srcB     = '0;
        alu_ctrl_sig = ALU_ADD;
        if (r_state == S_ITER) begin
            if (r_is_div) begin
                alu_srcA     = w_rem_shift;
                alu_srcB     = r_opnd;
                alu_ctrl_sig = ALU_SUB;
            end else begin
                alu_srcA     = r_acc;
                alu_srcB     = r_opnd;
            end
        end
    end

    assign w_carry  = alu_carry(alu_srcA[N-1], alu_srcB[N-1], alu_out[N-1]);
    assign w_borrow = alu_borrow(alu_srcA[N-1], alu_srcB[N-1], alu_out[N-1]);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_is_div    <= 1'b0;
            r_is_signed <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_opnd      <= '0;
            r_acc       <= '0;
            r_mq        <= '0;
            r_cnt       <= '0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div    <= is_div;
                        r_is_signed <= is_signed;
                        r_op_a      <= op_a;
                        r_op_b      <= op_b;
                        r_busy      <= 1'b1;
                        r_dbz       <= 1'b0;
                        r_state     <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_neg_res <= r_is_signed & (r_op_a[N-1] ^ r_op_b[N-1]);
                    r_neg_rem <= r_is_signed & r_op_a[N-1];
                    if (r_is_div && (r_op_b == '0)) begin
                        r_hi    <= r_op_a;
                        r_lo    <= '1;
                        r_dbz   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_mq    <= r_is_div ? w_abs_a : w_abs_b;
                        r_opnd  <= r_is_div ? w_abs_b : w_abs_a;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (r_is_div) begin
                        // Restore unless the shifted-out MSB guarantees the subtract fits.
                        if (r_acc[N-1] | ~w_borrow) begin
                            r_acc <= alu_out;
                            r_mq  <= w_q_shift | N'(1);
                        end else begin
                            r_acc <= w_rem_shift;
                            r_mq  <= w_q_shift;
                        end
                    end else if (r_mq[0]) begin
                        r_acc <= {w_carry, alu_out[N-1:1]};
                        r_mq  <= {alu_out[0], r_mq[N-1:1]};
                    end else begin
                        r_acc <= {1'b0, r_acc[N-1:1]};
                        r_mq  <= {r_acc[0], r_mq[N-1:1]};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_lo <= w_q_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: models the shared ALU, checks results, latency,
// busy/done framing, ALU control per cycle, ignored start pulses and async abort.
module tb_muldiv_sequencer;

    localparam int N = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         is_div;
    logic         is_signed;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] alu_srcA;
    logic [N-1:0] alu_srcB;
    logic [2:0]   alu_ctrl_sig;
    logic [N-1:0] alu_out;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    int vectors = 0;
    int errors  = 0;

    muldiv_sequencer #(.N(N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .is_div       (is_div),
        .is_signed    (is_signed),
        .op_a         (op_a),
        .op_b         (op_b),
        .alu_srcA     (alu_srcA),
        .alu_srcB     (alu_srcB),
        .alu_ctrl_sig (alu_ctrl_sig),
        .alu_out      (alu_out),
        .busy         (busy),
        .done         (done),
        .div_by_zero  (div_by_zero),
        .hi           (hi),
        .lo           (lo)
    );

    // Shared execute-stage ALU: add for 010, subtract for 110.
    assign alu_out = (alu_ctrl_sig == 3'b110) ? (alu_srcA - alu_srcB) : (alu_srcA + alu_srcB);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op, waits for done (bounded), checks latency, results, busy and ALU control.
    task automatic run_op(input string tag, input logic d, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic ez, input int elat, input bit poke);
        int cyc;
        int bad_ctrl;
        int busy_low;
        logic [2:0] ectl;
        @(posedge clk); #1;
        start = 1'b1; is_div = d; is_signed = s; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; bad_ctrl = 0; busy_low = 0;
        while (!done && cyc < 100) begin
            if (!busy) busy_low++;
            ectl = (d && !ez && cyc >= 2 && cyc <= N + 1) ? 3'b110 : 3'b010;
            if (alu_ctrl_sig !== ectl) bad_ctrl++;
            if (poke && cyc == 10) begin
                start = 1'b1; is_div = ~d; op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0003;
            end
            if (poke && cyc == 11) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, 64'(cyc), 64'(elat));
        check({tag, ".hi"}, 64'(hi), 64'(eh));
        check({tag, ".lo"}, 64'(lo), 64'(el));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(ez));
        check({tag, ".busy_low"}, 64'(busy_low + (busy ? 0 : 1)), 64'(0));
        check({tag, ".ctrl"}, 64'(bad_ctrl), 64'(0));
        if (poke) begin
            start = 1'b1; op_a = 32'h0000_0009; op_b = 32'h0000_0002;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".done_pulse"}, 64'(done), 64'(0));
        check({tag, ".idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; is_div = 1'b0; is_signed = 1'b0;
        op_a = '0; op_b = '0;
        #12;
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        check("rst.hilo", {hi, lo}, 64'(0));
        check("rst.alu", {29'(0), alu_ctrl_sig, alu_srcA}, {29'(0), 3'b010, 32'(0)});
        reset_n = 1'b1;

        run_op("multu_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, N + 3, 1'b0);
        run_op("mult_m7x3", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, N + 3, 1'b0);
        run_op("div_m7d2",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, N + 3, 1'b0);
        run_op("divu_dz",   1'b1, 1'b0, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 2, 1'b0);
        run_op("div_ovf",   1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, N + 3, 1'b0);
        run_op("multu_shf", 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, N + 3, 1'b0);
        run_op("div_7dm2",  1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, N + 3, 1'b0);
        run_op("mult_zero", 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 1'b0, N + 3, 1'b0);
        run_op("divu_5d7",  1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0000_0005, 32'h0000_0000, 1'b0, N + 3, 1'b0);
        run_op("mult_minsq",1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, N + 3, 1'b0);
        run_op("div_m8dm3", 1'b1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0, N + 3, 1'b0);
        run_op("poke_mult", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, N + 3, 1'b1);
        run_op("poke_divu", 1'b1, 1'b0, 32'h0000_03E8, 32'h0000_0007, 32'h0000_0006, 32'h0000_008E, 1'b0, N + 3, 1'b1);
        run_op("div_dz_neg",1'b1, 1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 2, 1'b0);

        // Abort in the middle of ITER (count 10) with an asynchronous reset.
        @(posedge clk); #1;
        start = 1'b1; is_div = 1'b1; is_signed = 1'b0; op_a = 32'd1000; op_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        check("abort.ctrl_iter", 64'(alu_ctrl_sig), 64'(3'b110));
        check("abort.srcB_iter", 64'(alu_srcB), 64'(32'd7));
        reset_n = 1'b0;
        #1;
        check("abort.busy", 64'(busy), 64'(0));
        check("abort.flags", {62'(0), done, div_by_zero}, 64'(0));
        check("abort.hilo", {hi, lo}, 64'(0));
        check("abort.alu", {29'(0), alu_ctrl_sig, alu_srcA}, {29'(0), 3'b010, 32'(0)});
        @(posedge clk); #3;
        check("abort.no_done", 64'(done), 64'(0));
        reset_n = 1'b1;

        run_op("divu_17d5", 1'b1, 1'b0, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0, N + 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer that implements MIPS `mult`, `multu`, `div` and `divu` by driving the shared N-bit ALU through N add/subtract iterations.
- Multiply uses shift-add; divide uses restoring division.
- Results go to the HI/LO registers it owns.
- Sits beside the execute stage: while `busy`, the sequencer owns the ALU source/control inputs and the hazard unit stalls the pipeline.

## Interface
Parameters:
- `N`, 32, operand/ALU width.

Ports:
- `clk`  in  1  clock. One clock; all state updates on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `is_div`  in  1  1 = divide, 0 = multiply; sampled with `start`.
- `is_signed`  in  1  1 = signed (`mult`/`div`); sampled with `start`.
- `op_a`, `op_b`  in  N  multiplicand/dividend, multiplier/divisor; sampled with `start`.
- `alu_srcA`, `alu_srcB`  out  N  operands driven to the shared ALU.
- `alu_ctrl_sig`  out  3  ALU op: 3'b010 add, 3'b110 sub.
- `alu_out`  in  N  ALU result, combinational, same cycle.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  one-cycle pulse when `hi`/`lo` become valid.
- `div_by_zero`  out  1  valid with `done`; held until the next accepted `start`.
- `hi`, `lo`  out  N  result registers; held until the next completion.

## Operation
- FSM states: IDLE, PREP, ITER, FIX, DONE.
- **IDLE**
  - `start`=1 latches the operation and operands; next state PREP.
  - `start` is ignored in every other state.
- **PREP**
  - Signed ops: latch |op_a| and |op_b|; record the sign of the result and of the remainder (the dividend's sign).
  - Divide with op_b==0:
    - Set `hi`=op_a and `lo`={N{1'b1}}, `div_by_zero`=1.
    - Next state DONE; ITER and FIX are skipped.
  - Otherwise clear the accumulator and the iteration counter; next state ITER.
- **ITER**: exactly N cycles; counter runs 0..N-1.
  - Multiply (acc:mq, 2N bits):
    - If mq[0]=1, ALU adds acc+mcand (ctrl 010).
    - carry = (a[N-1]&b[N-1]) | ((a[N-1]|b[N-1]) & ~sum[N-1]).
    - {acc,mq} ← {carry,alu_out,mq[N-1:1]}.
    - If mq[0]=0, shift right only. The ALU is still driven with add, but the result is unused.
  - Divide (rem:q):
    - Shift {rem,q} left by 1; `msb` is the bit shifted out of rem.
    - ALU computes rem_shifted−divisor (ctrl 110).
    - borrow = (~a[N-1]&b[N-1]) | (~(a[N-1]^b[N-1]) & diff[N-1]).
    - If msb | ~borrow: rem ← alu_out, q[0] ← 1. Otherwise rem ← rem_shifted, q[0] ← 0.
  - After count N-1, next state FIX.
- **FIX**
  - Signed results are negated where required: 2N-bit negate for a product; quotient and remainder negated separately.
  - Multiply: `hi`=upper half, `lo`=lower half.
  - Divide: `lo`=quotient, `hi`=remainder.
  - Negation uses local logic, not the ALU.
- **DONE**: `done`=1 for one cycle, then IDLE.
- Overflow case `div` 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No exception.
- When not in ITER: `alu_srcA`=`alu_srcB`=0, `alu_ctrl_sig`=3'b010.

## Timing
- Reset (async, `reset_n`=0): state IDLE.
  - `busy`=0, `done`=0, `div_by_zero`=0.
  - `hi`=`lo`=0.
  - ALU outputs are at their idle values.
- Reset mid-operation aborts immediately; no `done` is produced.
- Latency for `start` sampled at edge 0:
  - PREP in cycle 1.
  - ITER in cycles 2..N+1.
  - FIX in cycle N+2.
  - DONE (`done`=1, `hi`/`lo` valid) in cycle N+3.
- Divide-by-zero: DONE in cycle 2.
- `busy` is asserted in cycles 1 through DONE inclusive.
  - `start` held high during DONE is ignored.
  - `start` is accepted on the cycle DONE returns to IDLE.
- The ALU path is combinational within one ITER cycle. alu_out → acc/rem register is the critical path.

## Structure
- `muldiv_pkg` holds:
  - the state enum;
  - the ALU control constants ALU_ADD=3'b010 and ALU_SUB=3'b110;
  - carry/borrow helper functions.
- One sub-module, `cond_neg #(W)`: conditional two's-complement negate, instantiated for PREP absolute value (W=N) and FIX correction (W=N and W=2N).
- The ALU itself is not instantiated here; the top level muxes ALU inputs on `busy`.

## Test plan
- `multu` 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; `done` exactly N+3 cycles after `start`.
- `mult` −7 × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; `div` −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- `divu` 100 / 0 → `div_by_zero`=1, lo=0xFFFFFFFF, hi=100, `done` at cycle 2; `div` 0x80000000 / −1 → lo=0x80000000, hi=0.
- `start` pulsed during ITER and during DONE → ignored. Results match the first op; `busy` is never deasserted early.
- `reset_n` dropped at ITER count 10 → asynchronously: all outputs 0, state IDLE. A new `divu` 17/5 then completes with lo=3, hi=2.
- Random 10k signed/unsigned ops against a reference model. Check the ALU ctrl sequence: only 010 for mul and only 110 for div during ITER.
